// File: rtl/ps2_keycode_decoder_if.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_keycode_decoder_if
//  Brief    : PS/2 pin inputs and decoded keycode outputs of the keycode decoder.
//  Revision : 1.0 - initial release
// ============================================================================
interface ps2_keycode_decoder_if;
    logic       PS2_CLK;
    logic       PS2_DAT;
    logic [7:0] keycode;
    logic       key_changed;
    logic       frame_err;

    // The master drives the pins (board / keyboard side); the slave is the decoder.
    modport master (
        output PS2_CLK,
        output PS2_DAT,
        input  keycode,
        input  key_changed,
        input  frame_err
    );

    modport slave (
        input  PS2_CLK,
        input  PS2_DAT,
        output keycode,
        output key_changed,
        output frame_err
    );
endinterface
`default_nettype wire

// File: rtl/ps2_keycode_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_keycode_decoder
//  Brief    : PS/2 set-2 receiver with F0/E0 prefix handling and HID translation.
//  Revision : 1.0 - initial release
// ============================================================================
module ps2_keycode_decoder #(
    parameter logic [3:0]  FILTER_LEN  = 4'd8,
    parameter logic [16:0] TIMEOUT_CYC = 17'd100000
) (
    input  logic                    Clk,
    input  logic                    Reset,
    ps2_keycode_decoder_if.slave    bus
);

    localparam logic [7:0] c_BREAK_PREFIX = 8'hF0;
    localparam logic [7:0] c_EXT_PREFIX   = 8'hE0;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    logic        r_clk_meta, r_clk_sync;
    logic        r_dat_meta, r_dat_sync;
    logic        r_filt_clk, r_filt_prev;
    logic [3:0]  r_filt_cnt;
    logic        w_fall;

    state_t      r_state, w_state_next;
    logic [2:0]  r_bit_cnt, w_bit_cnt_next;
    logic [7:0]  r_shift, w_shift_next;
    logic        r_parity, w_parity_next;
    logic [16:0] r_timeout, w_timeout_next;
    logic        w_byte_done;
    logic        w_frame_err;

    logic        w_mapped;
    logic [7:0]  w_usage;
    logic        r_break, r_ext;
    logic [7:0]  r_keycode;
    logic        r_key_changed;
    logic        r_frame_err;

    // Synchronizers idle high so that reset never manufactures a falling edge.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_clk_meta <= 1'b1;
            r_clk_sync <= 1'b1;
            r_dat_meta <= 1'b1;
            r_dat_sync <= 1'b1;
        end else begin
            r_clk_meta <= bus.PS2_CLK;
            r_clk_sync <= r_clk_meta;
            r_dat_meta <= bus.PS2_DAT;
            r_dat_sync <= r_dat_meta;
        end
    end

    // The filtered clock flips only after FILTER_LEN samples disagreeing with it in a row.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_filt_clk  <= 1'b1;
            r_filt_prev <= 1'b1;
            r_filt_cnt  <= 4'd0;
        end else begin
            r_filt_prev <= r_filt_clk;
            if (r_clk_sync == r_filt_clk) begin
                r_filt_cnt <= 4'd0;
            end else if (r_filt_cnt == FILTER_LEN - 4'd1) begin
                r_filt_clk <= r_clk_sync;
                r_filt_cnt <= 4'd0;
            end else begin
                r_filt_cnt <= r_filt_cnt + 4'd1;
            end
        end
    end

    assign w_fall = r_filt_prev & ~r_filt_clk;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state   <= S_IDLE;
            r_bit_cnt <= 3'd0;
            r_shift   <= 8'h00;
            r_parity  <= 1'b0;
            r_timeout <= 17'd0;
        end else begin
            r_state   <= w_state_next;
            r_bit_cnt <= w_bit_cnt_next;
            r_shift   <= w_shift_next;
            r_parity  <= w_parity_next;
            r_timeout <= w_timeout_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_bit_cnt_next = r_bit_cnt;
        w_shift_next   = r_shift;
        w_parity_next  = r_parity;
        w_timeout_next = 17'd0;
        w_byte_done    = 1'b0;
        w_frame_err    = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_fall && !r_dat_sync) begin
                    w_state_next   = S_DATA;
                    w_bit_cnt_next = 3'd0;
                end
            end
            S_DATA: begin
                if (w_fall) begin
                    w_shift_next[r_bit_cnt] = r_dat_sync;
                    if (r_bit_cnt == 3'd7) begin
                        w_state_next = S_PARITY;
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                if (w_fall) begin
                    w_parity_next = r_dat_sync;
                    w_state_next  = S_STOP;
                end
            end
            S_STOP: begin
                if (w_fall) begin
                    w_state_next = S_IDLE;
                    if ((^{r_shift, r_parity}) && r_dat_sync) begin
                        w_byte_done = 1'b1;
                    end else begin
                        w_frame_err = 1'b1;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase

        // A stalled keyboard mid-frame must not wedge the receiver.
        if (r_state != S_IDLE && !w_fall) begin
            if (r_timeout == TIMEOUT_CYC - 17'd1) begin
                w_state_next = S_IDLE;
                w_frame_err  = 1'b1;
            end else begin
                w_timeout_next = r_timeout + 17'd1;
            end
        end
    end

    always_comb begin
        w_mapped = 1'b1;
        w_usage  = 8'h00;
        case (r_shift)
            8'h1C:   w_usage = 8'h04;
            8'h23:   w_usage = 8'h07;
            8'h1B:   w_usage = 8'h16;
            8'h1D:   w_usage = 8'h1A;
            8'h29:   w_usage = 8'h2C;
            8'h5A:   w_usage = 8'h28;
            8'h76:   w_usage = 8'h29;
            default: w_mapped = 1'b0;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_break       <= 1'b0;
            r_ext         <= 1'b0;
            r_keycode     <= 8'h00;
            r_key_changed <= 1'b0;
            r_frame_err   <= 1'b0;
        end else begin
            r_key_changed <= 1'b0;
            r_frame_err   <= w_frame_err;
            if (w_byte_done) begin
                if (r_shift == c_BREAK_PREFIX) begin
                    r_break <= 1'b1;
                end else if (r_shift == c_EXT_PREFIX) begin
                    r_ext <= 1'b1;
                end else begin
                    r_break <= 1'b0;
                    r_ext   <= 1'b0;
                    if (!r_ext && w_mapped) begin
                        if (!r_break) begin
                            // Typematic repeats of the held key leave key_changed low.
                            if (w_usage != r_keycode) begin
                                r_keycode     <= w_usage;
                                r_key_changed <= 1'b1;
                            end
                        end else if (r_keycode == w_usage) begin
                            r_keycode     <= 8'h00;
                            r_key_changed <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign bus.keycode     = r_keycode;
    assign bus.key_changed = r_key_changed;
    assign bus.frame_err   = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_ps2_keycode_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ps2_keycode_decoder
//  Brief    : Directed self-checking bench for the PS/2 keycode decoder.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_keycode_decoder;

    localparam logic [16:0] c_TIMEOUT = 17'd3000;
    localparam int          c_HALF    = 20;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   n_kc;
    int   n_err;

    ps2_keycode_decoder_if u_if ();

    ps2_keycode_decoder #(
        .FILTER_LEN  (4'd8),
        .TIMEOUT_CYC (c_TIMEOUT)
    ) u_dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycles during which each pulse output was high.
    always @(negedge clk) begin
        if (u_if.key_changed === 1'b1) n_kc++;
        if (u_if.frame_err === 1'b1)   n_err++;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic v);
        u_if.PS2_DAT = v;
        wait_cyc(c_HALF);
        u_if.PS2_CLK = 1'b0;
        wait_cyc(c_HALF);
        u_if.PS2_CLK = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_parity);
        logic [10:0] fr;
        fr = {1'b1, (~^b) ^ bad_parity, b, 1'b0};
        for (int i = 0; i < 11; i++) send_bit(fr[i]);
        u_if.PS2_DAT = 1'b1;
        wait_cyc(60);
    endtask

    task automatic check_key(input string name, input logic [7:0] exp);
        checks++;
        if (u_if.keycode !== exp) begin
            errors++;
            $display("FAIL %s: keycode=%02h expected=%02h", name, u_if.keycode, exp);
        end
    endtask

    task automatic check_count(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: pulse cycles=%0d expected=%0d", name, got, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wait_cyc(2);
        rst = 1'b0;
        wait_cyc(1);
        check_key("reset_keycode", 8'h00);
        checks++;
        if (u_if.key_changed !== 1'b0) begin
            errors++;
            $display("FAIL reset_key_changed: got=%b expected=0", u_if.key_changed);
        end
        checks++;
        if (u_if.frame_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_frame_err: got=%b expected=0", u_if.frame_err);
        end
        n_kc  = 0;
        n_err = 0;
    endtask

    task automatic test_make();
        int kc0, er0;
        kc0 = n_kc; er0 = n_err;
        send_frame(8'h1D, 1'b0);
        check_key("make_w", 8'h1A);
        check_count("make_w_pulse", n_kc - kc0, 1);
        check_count("make_w_noerr", n_err - er0, 0);
        kc0 = n_kc;
        send_frame(8'h1D, 1'b0);
        check_key("repeat_w", 8'h1A);
        check_count("repeat_w_nopulse", n_kc - kc0, 0);
    endtask

    task automatic test_break();
        int kc0;
        send_frame(8'h1C, 1'b0);
        check_key("make_a", 8'h04);
        send_frame(8'h23, 1'b0);
        check_key("make_d", 8'h07);
        kc0 = n_kc;
        send_frame(8'hF0, 1'b0);
        send_frame(8'h1C, 1'b0);
        check_key("break_other", 8'h07);
        check_count("break_other_nopulse", n_kc - kc0, 0);
        kc0 = n_kc;
        send_frame(8'hF0, 1'b0);
        send_frame(8'h23, 1'b0);
        check_key("break_held", 8'h00);
        check_count("break_held_pulse", n_kc - kc0, 1);
    endtask

    task automatic test_parity_err();
        int kc0, er0;
        kc0 = n_kc; er0 = n_err;
        send_frame(8'h1B, 1'b1);
        check_count("parity_err_pulse", n_err - er0, 1);
        check_key("parity_err_key", 8'h00);
        check_count("parity_err_nokc", n_kc - kc0, 0);
        send_frame(8'h1B, 1'b0);
        check_key("make_s", 8'h16);
    endtask

    task automatic test_timeout();
        int er0;
        er0 = n_err;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        u_if.PS2_DAT = 1'b1;
        wait_cyc(int'(c_TIMEOUT) + 200);
        check_count("timeout_err_pulse", n_err - er0, 1);
        check_key("timeout_key", 8'h16);
        send_frame(8'h5A, 1'b0);
        check_key("make_enter", 8'h28);
    endtask

    task automatic test_glitch_ext();
        int kc0, er0;
        kc0 = n_kc; er0 = n_err;
        for (int i = 0; i < 6; i++) begin
            u_if.PS2_CLK = 1'b0;
            wait_cyc(3);
            u_if.PS2_CLK = 1'b1;
            wait_cyc(15);
        end
        check_count("glitch_nokc", n_kc - kc0, 0);
        check_count("glitch_noerr", n_err - er0, 0);
        check_key("glitch_key", 8'h28);
        send_frame(8'hE0, 1'b0);
        send_frame(8'h1D, 1'b0);
        check_key("ext_ignored", 8'h28);
        check_count("ext_nokc", n_kc - kc0, 0);
        send_frame(8'h1D, 1'b0);
        check_key("after_ext_w", 8'h1A);
    endtask

    task automatic test_translation();
        logic [7:0] codes [7];
        logic [7:0] usages [7];
        int kc0;
        codes  = '{8'h1C, 8'h23, 8'h1B, 8'h1D, 8'h29, 8'h5A, 8'h76};
        usages = '{8'h04, 8'h07, 8'h16, 8'h1A, 8'h2C, 8'h28, 8'h29};
        send_frame(8'h1C, 1'b0);
        for (int i = 1; i < 7; i++) begin
            send_frame(codes[i], 1'b0);
            check_key($sformatf("xlate_%02h", codes[i]), usages[i]);
        end
        kc0 = n_kc;
        send_frame(8'h15, 1'b0);
        check_key("unmapped_key", 8'h29);
        check_count("unmapped_nokc", n_kc - kc0, 0);
    endtask

    task automatic test_reset_mid_frame();
        int er0;
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b0);
        rst = 1'b1;
        wait_cyc(2);
        rst = 1'b0;
        u_if.PS2_DAT = 1'b1;
        wait_cyc(20);
        check_key("midreset_key", 8'h00);
        er0 = n_err;
        send_frame(8'h1C, 1'b0);
        check_key("after_midreset_a", 8'h04);
        check_count("after_midreset_noerr", n_err - er0, 0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        n_kc   = 0;
        n_err  = 0;
        rst    = 1'b1;
        u_if.PS2_CLK = 1'b1;
        u_if.PS2_DAT = 1'b1;
        wait_cyc(3);
        test_reset();
        test_make();
        test_break();
        test_parity_err();
        test_timeout();
        test_glitch_ext();
        test_translation();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
